spi_master: RTL and testbench
=============================

# spi_master

SPI bus master for the SPI subsystem: accepts a byte and a one-hot slave select on its control port, runs one 8-bit full-duplex SPI transfer (mode 0, MSB first), and returns the byte shifted in on MISO. It drives the shared SPI bus (`SPIbus`, `Master` modport) and is controlled through an `SPIctrl` interface (`Master` modport). It sits opposite up to two `slave` instances on the same bus.

## Interface
- `SCK_HALF`, default 2: `Clk_i` cycles per SCK half-period; minimum 1.
- `Clk_i`, in, 1: single system clock. All logic is on the rising edge.
- `Rst_ni`, in, 1: reset. Asynchronous and active-low.
- `ToXmit_i`, in, 8: byte to transmit (`Ctrl.toXmit`).
- `Strobe_i`, in, 1: request (`Ctrl.strobe`). Acted on at its 0→1 edge; may be held high for several cycles.
- `Ss_i`, in, 2: one-hot target slave (`Ctrl.ss`).
- `Rcvd_o`, out, 8: last byte received from MISO (`Ctrl.Rcvd`).
- `Ready_o`, out, 1: `Rcvd_o` is valid (`Ctrl.Ready`).
- `XmitFull_o`, out, 1: request latched but not yet loaded into the shifter (`Ctrl.XmitFull`).
- `Busy_o`, out, 1: transfer in progress (`Ctrl.busy`).
- `Miso_i`, in, 1: serial data from the selected slave (`Spim.miso`).
- `Mosi_o`, out, 1: serial data to the slaves (`Spim.mosi`).
- `Sck_o`, out, 1: serial clock (`Spim.sck`). Idles low.
- `Ss_o`, out, 2: bus slave selects (`Spim.ss`). Active-high, one-hot.

## Operation
- Reset values: `Sck_o`=0, `Mosi_o`=0, `Ss_o`=00, `Rcvd_o`=00h, `Ready_o`=0, `XmitFull_o`=0, `Busy_o`=0. The FSM returns to IDLE.
- Reset asserted mid-transfer aborts the transfer immediately. No partial byte is reported.
- Strobe acceptance:
  - A registered 0→1 edge of `Strobe_i` with `XmitFull_o`=0 latches `ToXmit_i` and `Ss_i` into a holding register and sets `XmitFull_o`=1.
  - An edge while `XmitFull_o`=1 is ignored; the held request is kept.
  - An edge while `Busy_o`=1 with `XmitFull_o`=0 is accepted and queued.
- FSM states: IDLE, LEAD, HIGH, LOW, TRAIL.
  - IDLE → LEAD when `XmitFull_o`=1. In the same cycle: load the shifter, clear `XmitFull_o`, set `Busy_o`=1, clear `Ready_o`, drive `Ss_o` from the latched select, and put bit 7 on `Mosi_o`.
  - LEAD (SCK_HALF cycles) → HIGH. `Sck_o` goes 1.
  - HIGH (SCK_HALF cycles): on the last cycle, sample `Miso_i` into bit 0 of the receive shifter (left shift). This places the sample as late as possible to absorb slave synchronizer delay. Then → LOW with `Sck_o`=0.
  - LOW (SCK_HALF cycles): on entry, shift the next bit onto `Mosi_o`. After 8 bits → TRAIL, otherwise → HIGH.
  - TRAIL (SCK_HALF cycles) → IDLE. On exit: `Ss_o`=00, `Mosi_o`=0, `Rcvd_o`=received byte, `Ready_o`=1, `Busy_o`=0.
- `Ready_o` stays high until the next transfer starts, so each completion produces a fresh rising edge. `Rcvd_o` holds its value until the next completion.
- `Ss_i`=00: the transfer still runs with `Ss_o`=00 and `Rcvd_o` takes whatever is on `Miso_i`.
- `Ss_i`=11: driven as given. Avoiding this is the user's responsibility.
- A queued request starts in the cycle after TRAIL exits (IDLE for one cycle).

## Timing
- Strobe edge to `XmitFull_o`=1: 1 cycle after the edge is registered.
- `XmitFull_o`=1 to `Busy_o`=1: 1 cycle when idle.
- Transfer length from `Busy_o` rising to `Ready_o` rising: 18·SCK_HALF cycles, which is 36 at the default.
- Idle strobe to `Ready_o`: 18·SCK_HALF + 3 cycles, which is 39 at the default. This fits inside the 50-cycle request spacing used by the system.
- SCK period: 2·SCK_HALF clocks.
- `Mosi_o` is stable at least SCK_HALF cycles before each SCK rising edge.

## Structure
- Shared package `spi_pkg` holds:
  - `DATA_W`=8 and `NUM_SS`=2;
  - the FSM state enum `spi_state_e`.
- `SPIbus` and `SPIctrl` interfaces with `Master`/`Slave` modports live alongside the package. The top-level master binds `Ctrl` (SPIctrl.Master) and `Spim` (SPIbus.Master) to the flat ports above.
- One sub-module: `spi_clk_div`, the SCK_HALF down-counter producing the phase-tick. Everything else stays in `spi_master`.

## Test plan
- Reset: hold `Rst_ni`=0 for 1 cycle → all outputs at their reset values; `Sck_o` idles 0.
- Loopback: `Miso_i` tied to `Mosi_o`, strobe with `ToXmit_i`=A5h and `Ss_i`=01 → `Ss_o`=01 during the transfer; 8 SCK pulses with MOSI 1,0,1,0,0,1,0,1; `Rcvd_o`=A5h and `Ready_o` rises 36 cycles after `Busy_o`.
- Slave model on `Ss_o[1]` returns 3Ch while master sends C3h with `Ss_i`=10 → `Rcvd_o`=3Ch, `Ss_o[0]` stays 0 throughout.
- Second strobe during a transfer, then a third before the first completes → the second request is queued (`XmitFull_o`=1) and starts right after TRAIL; the third is ignored.
- Reset asserted in the middle of bit 4 → outputs return to reset values immediately; with no new strobe, `Ready_o` stays 0.
- 100 back-to-back random bytes with random `Ss_i` ∈ {01,10}, spaced 50 cycles, against two slave models → every `Rcvd_o` matches the selected slave's byte, with no overlap or dropped request.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared constants and FSM state type for the SPI master/slave subsystem.
package spi_pkg;

  localparam int DATA_W = 8;
  localparam int NUM_SS = 2;
  // Wide enough to hold the value DATA_W itself (bits-done counter).
  localparam int BIT_CW = $clog2(DATA_W + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEAD,
    ST_HIGH,
    ST_LOW,
    ST_TRAIL
  } spi_state_e;

endpackage

// File: rtl/spi_clk_div.sv
// SCK half-period divider: emits a one-cycle tick every SCK_HALF clocks.
// Held in reload while restart is high so each phase starts on a full count.
module spi_clk_div #(
  parameter int SCK_HALF = 2
) (
  input  logic Clk_i,
  input  logic Rst_ni,
  input  logic restart,
  output logic tick
);

  localparam int CW = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(SCK_HALF - 1);

  logic [CW-1:0] cnt;

  // Down-counter; reloads on restart or when it reaches zero.
  always_ff @(posedge Clk_i or negedge Rst_ni) begin
    if (!Rst_ni) begin
      cnt <= RELOAD;
    end else if (restart || tick) begin
      cnt <= RELOAD;
    end else begin
      cnt <= cnt - CW'(1);
    end
  end

  assign tick = (cnt == '0);

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 master: one 8-bit MSB-first full-duplex transfer per strobe,
// with a single-entry holding register so one request can queue behind a
// running transfer.
module spi_master
  import spi_pkg::*;
#(
  parameter int SCK_HALF = 2
) (
  input  logic              Clk_i,
  input  logic              Rst_ni,
  input  logic [DATA_W-1:0] ToXmit_i,
  input  logic              Strobe_i,
  input  logic [NUM_SS-1:0] Ss_i,
  output logic [DATA_W-1:0] Rcvd_o,
  output logic              Ready_o,
  output logic              XmitFull_o,
  output logic              Busy_o,
  input  logic              Miso_i,
  output logic              Mosi_o,
  output logic              Sck_o,
  output logic [NUM_SS-1:0] Ss_o
);

  spi_state_e state_q, state_d;

  logic              strobe_p1, strobe_p2;
  logic              strobe_rise;
  logic              accept;
  logic [DATA_W-1:0] hold_data;
  logic [NUM_SS-1:0] hold_ss;
  logic [DATA_W-2:0] tx_sr;
  logic [DATA_W-1:0] rx_sr;
  logic [BIT_CW-1:0] bit_cnt;
  logic              tick;
  logic              load, sample, shift_out, sck_up, finish;

  assign strobe_rise = strobe_p1 & ~strobe_p2;
  assign accept      = strobe_rise & ~XmitFull_o;

  spi_clk_div #(.SCK_HALF(SCK_HALF)) u_clk_div (
    .Clk_i  (Clk_i),
    .Rst_ni (Rst_ni),
    .restart(state_q == ST_IDLE),
    .tick   (tick)
  );

  // FSM state register.
  always_ff @(posedge Clk_i or negedge Rst_ni) begin
    if (!Rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic and per-cycle action strobes.
  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    sample    = 1'b0;
    shift_out = 1'b0;
    sck_up    = 1'b0;
    finish    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (XmitFull_o) begin
          state_d = ST_LEAD;
          load    = 1'b1;
        end
      end
      ST_LEAD: begin
        if (tick) begin
          state_d = ST_HIGH;
          sck_up  = 1'b1;
        end
      end
      ST_HIGH: begin
        // Sample on the last HIGH cycle to absorb slave synchronizer delay.
        if (tick) begin
          state_d   = ST_LOW;
          sample    = 1'b1;
          shift_out = 1'b1;
        end
      end
      ST_LOW: begin
        if (tick) begin
          if (bit_cnt == BIT_CW'(DATA_W)) begin
            state_d = ST_TRAIL;
          end else begin
            state_d = ST_HIGH;
            sck_up  = 1'b1;
          end
        end
      end
      ST_TRAIL: begin
        if (tick) begin
          state_d = ST_IDLE;
          finish  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and bus outputs: strobe edge detect, handshake flags, SCK/MOSI/SS.
  always_ff @(posedge Clk_i or negedge Rst_ni) begin
    if (!Rst_ni) begin
      strobe_p1  <= 1'b0;
      strobe_p2  <= 1'b0;
      XmitFull_o <= 1'b0;
      Busy_o     <= 1'b0;
      Ready_o    <= 1'b0;
      Rcvd_o     <= '0;
      Ss_o       <= '0;
      Mosi_o     <= 1'b0;
      Sck_o      <= 1'b0;
      bit_cnt    <= '0;
    end else begin
      strobe_p1 <= Strobe_i;
      strobe_p2 <= strobe_p1;
      if (load)        XmitFull_o <= 1'b0;
      else if (accept) XmitFull_o <= 1'b1;
      if (load) begin
        Busy_o  <= 1'b1;
        Ready_o <= 1'b0;
        Ss_o    <= hold_ss;
        Mosi_o  <= hold_data[DATA_W-1];
        bit_cnt <= '0;
      end else if (finish) begin
        Busy_o  <= 1'b0;
        Ready_o <= 1'b1;
        Ss_o    <= '0;
        Mosi_o  <= 1'b0;
        Rcvd_o  <= rx_sr;
      end else if (shift_out) begin
        Mosi_o  <= tx_sr[DATA_W-2];
        bit_cnt <= bit_cnt + BIT_CW'(1);
      end
      if (sck_up)         Sck_o <= 1'b1;
      else if (shift_out) Sck_o <= 1'b0;
    end
  end

  // Data registers: holding register and shifters carry no reset.
  always_ff @(posedge Clk_i) begin
    if (accept) begin
      hold_data <= ToXmit_i;
      hold_ss   <= Ss_i;
    end
    if (load)           tx_sr <= hold_data[DATA_W-2:0];
    else if (shift_out) tx_sr <= {tx_sr[DATA_W-3:0], 1'b0};
    if (sample)         rx_sr <= {rx_sr[DATA_W-2:0], Miso_i};
  end

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master with loopback and two slave models.
module tb_spi_master;

  logic       Clk_i, Rst_ni;
  logic [7:0] ToXmit_i;
  logic       Strobe_i;
  logic [1:0] Ss_i;
  logic [7:0] Rcvd_o;
  logic       Ready_o, XmitFull_o, Busy_o;
  logic       Miso_i, Mosi_o, Sck_o;
  logic [1:0] Ss_o;

  spi_master #(.SCK_HALF(2)) dut (
    .Clk_i(Clk_i), .Rst_ni(Rst_ni), .ToXmit_i(ToXmit_i), .Strobe_i(Strobe_i),
    .Ss_i(Ss_i), .Rcvd_o(Rcvd_o), .Ready_o(Ready_o), .XmitFull_o(XmitFull_o),
    .Busy_o(Busy_o), .Miso_i(Miso_i), .Mosi_o(Mosi_o), .Sck_o(Sck_o), .Ss_o(Ss_o)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int n_done = 0;
  int sck_pulses = 0;
  int busy_rise_cyc = 0, ready_rise_cyc = 0, xf_rise_cyc = 0, strobe_cyc = 0;
  int last_len = 0, last_gap = 0, last_xf2busy = 0, last_strobe2rdy = 0;
  logic [7:0] mosi_bits = '0;
  logic       ss0_seen = 1'b0, ss_any = 1'b0;
  logic       loopback = 1'b1;
  logic [7:0] s0_byte = '0, s1_byte = '0, s0_sr = '0, s1_sr = '0;
  logic [7:0] exp_q[$];

  assign Miso_i = loopback ? Mosi_o :
                  (Ss_o[0] ? s0_sr[7] : (Ss_o[1] ? s1_sr[7] : 1'b0));

  initial begin
    Clk_i = 1'b0;
    forever #5 Clk_i = ~Clk_i;
  end

  always @(posedge Clk_i) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge Clk_i);
  endtask

  // One strobe pulse; optionally records the byte the scoreboard should see.
  task automatic strobe(input logic [7:0] data, input logic [1:0] ss,
                        input bit push, input logic [7:0] expect_byte);
    @(negedge Clk_i);
    ToXmit_i   = data;
    Ss_i       = ss;
    Strobe_i   = 1'b1;
    strobe_cyc = cyc;
    if (push) exp_q.push_back(expect_byte);
    wait_cycles(2);
    Strobe_i = 1'b0;
    wait_cycles(1);
  endtask

  // Monitor: slave models, SCK/MOSI capture, timing stamps, scoreboard pop.
  initial begin
    logic [1:0] ss_prev = '0;
    logic       sck_prev = 1'b0, rdy_prev = 1'b0, busy_prev = 1'b0, xf_prev = 1'b0;
    forever begin
      @(negedge Clk_i);
      if (Ss_o[0] && !ss_prev[0]) s0_sr = s0_byte;
      else if (!Sck_o && sck_prev) s0_sr = {s0_sr[6:0], 1'b0};
      if (Ss_o[1] && !ss_prev[1]) s1_sr = s1_byte;
      else if (!Sck_o && sck_prev) s1_sr = {s1_sr[6:0], 1'b0};
      if (Ss_o[0]) ss0_seen = 1'b1;
      if (Ss_o != 2'b00) ss_any = 1'b1;
      if (XmitFull_o && !xf_prev) xf_rise_cyc = cyc;
      if (Busy_o && !busy_prev) begin
        busy_rise_cyc = cyc;
        last_gap      = cyc - ready_rise_cyc;
        last_xf2busy  = cyc - xf_rise_cyc;
        sck_pulses    = 0;
        mosi_bits     = '0;
      end
      if (Sck_o && !sck_prev) begin
        sck_pulses++;
        mosi_bits = {mosi_bits[6:0], Mosi_o};
      end
      if (Ready_o && !rdy_prev) begin
        ready_rise_cyc  = cyc;
        last_len        = cyc - busy_rise_cyc;
        last_strobe2rdy = cyc - strobe_cyc;
        n_done++;
        check("sb_pending", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("rcvd", 32'(Rcvd_o), 32'(exp_q.pop_front()));
      end
      ss_prev = Ss_o; sck_prev = Sck_o; rdy_prev = Ready_o;
      busy_prev = Busy_o; xf_prev = XmitFull_o;
    end
  end

  initial begin
    logic [7:0] tx, b0, b1;
    logic [1:0] ss;
    Rst_ni = 1'b0; ToXmit_i = '0; Strobe_i = 1'b0; Ss_i = '0;

    // Reset values
    @(negedge Clk_i);
    check("rst_sck", 32'(Sck_o), 32'd0);
    check("rst_mosi", 32'(Mosi_o), 32'd0);
    check("rst_ss", 32'(Ss_o), 32'd0);
    check("rst_rcvd", 32'(Rcvd_o), 32'h00);
    check("rst_ready", 32'(Ready_o), 32'd0);
    check("rst_xfull", 32'(XmitFull_o), 32'd0);
    check("rst_busy", 32'(Busy_o), 32'd0);
    Rst_ni = 1'b1;
    wait_cycles(3);

    // Loopback A5h to slave 0
    loopback = 1'b1;
    strobe(8'hA5, 2'b01, 1'b1, 8'hA5);
    wait_cycles(8);
    check("lb_ss_during", 32'(Ss_o), 32'b01);
    check("lb_busy_during", 32'(Busy_o), 32'd1);
    wait_cycles(50);
    check("lb_sck_pulses", 32'(sck_pulses), 32'd8);
    check("lb_mosi_bits", 32'(mosi_bits), 32'hA5);
    check("lb_busy_to_ready", 32'(last_len), 32'd36);
    check("lb_xfull_to_busy", 32'(last_xf2busy), 32'd1);
    check("lb_strobe_to_ready", 32'(last_strobe2rdy), 32'd39);
    check("lb_ready_held", 32'(Ready_o), 32'd1);
    check("lb_rcvd_held", 32'(Rcvd_o), 32'hA5);
    check("lb_ss_idle", 32'(Ss_o), 32'd0);
    check("lb_sck_idle", 32'(Sck_o), 32'd0);

    // Slave 1 returns 3Ch while master sends C3h
    loopback = 1'b0; s1_byte = 8'h3C; s0_byte = 8'h81; ss0_seen = 1'b0;
    strobe(8'hC3, 2'b10, 1'b1, 8'h3C);
    wait_cycles(50);
    check("sl_mosi_bits", 32'(mosi_bits), 32'hC3);
    check("sl_ss0_quiet", 32'(ss0_seen), 32'd0);
    check("sl_sb_empty", 32'(exp_q.size()), 32'd0);

    // No slave selected: transfer still runs, bus selects stay low
    loopback = 1'b1; ss_any = 1'b0;
    strobe(8'h3C, 2'b00, 1'b1, 8'h3C);
    wait_cycles(50);
    check("ss00_no_select", 32'(ss_any), 32'd0);
    check("ss00_pulses", 32'(sck_pulses), 32'd8);

    // Queued second request, ignored third
    strobe(8'h96, 2'b01, 1'b1, 8'h96);
    wait_cycles(5);
    strobe(8'h69, 2'b10, 1'b1, 8'h69);
    check("q_xfull_set", 32'(XmitFull_o), 32'd1);
    check("q_busy_first", 32'(Busy_o), 32'd1);
    strobe(8'hFF, 2'b01, 1'b0, 8'h00);
    check("q_xfull_kept", 32'(XmitFull_o), 32'd1);
    wait_cycles(100);
    check("q_start_gap", 32'(last_gap), 32'd1);
    check("q_done_count", 32'(n_done), 32'd5);
    check("q_rcvd_last", 32'(Rcvd_o), 32'h69);
    check("q_sb_empty", 32'(exp_q.size()), 32'd0);
    check("q_idle_busy", 32'(Busy_o), 32'd0);
    check("q_idle_xfull", 32'(XmitFull_o), 32'd0);

    // Reset in the middle of bit 4
    strobe(8'h5A, 2'b01, 1'b0, 8'h00);
    for (int i = 0; i < 200 && sck_pulses < 4; i++) @(negedge Clk_i);
    check("bit4_reached", 32'(sck_pulses >= 4), 32'd1);
    @(negedge Clk_i);
    #2 Rst_ni = 1'b0;
    #1;
    check("mid_rst_sck", 32'(Sck_o), 32'd0);
    check("mid_rst_mosi", 32'(Mosi_o), 32'd0);
    check("mid_rst_ss", 32'(Ss_o), 32'd0);
    check("mid_rst_busy", 32'(Busy_o), 32'd0);
    check("mid_rst_ready", 32'(Ready_o), 32'd0);
    check("mid_rst_rcvd", 32'(Rcvd_o), 32'h00);
    check("mid_rst_xfull", 32'(XmitFull_o), 32'd0);
    @(negedge Clk_i);
    Rst_ni = 1'b1;
    wait_cycles(60);
    check("post_rst_ready", 32'(Ready_o), 32'd0);
    check("post_rst_busy", 32'(Busy_o), 32'd0);
    check("post_rst_done", 32'(n_done), 32'd5);

    // 100 random transfers against the two slave models, 50-cycle spacing
    loopback = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tx = 8'($urandom); b0 = 8'($urandom); b1 = 8'($urandom);
      ss = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
      s0_byte = b0; s1_byte = b1;
      strobe(tx, ss, 1'b1, ss[0] ? b0 : b1);
      wait_cycles(47);
    end
    wait_cycles(10);
    check("rnd_done_count", 32'(n_done), 32'd105);
    check("rnd_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
